// File: rtl/alu_flag_stage_pkg.sv
// Shared ALU definitions: opcodes, {Z,V,N} flag bit positions, buffered-entry metadata.
// Also holds the opcode -> flag-update mask decode used at commit.
package alu_flag_stage_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SRA    = 4'b0100,
        OP_SLL    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111
    } opcode_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic [3:0] opcode;
        logic       ovfl;
    } meta_t;

    // Arithmetic ops own all flags; logical/shift ops only report zero.
    function automatic logic [2:0] flag_mask(input logic [3:0] op);
        logic [2:0] mask;
        mask = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SRA, OP_SLL, OP_ROR: mask[FLAG_Z] = 1'b1;
            default:                        mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/alu_skid_fifo.sv
// Two-entry FIFO holding {meta, result}; 1-cycle fill latency, head gated to 0 when empty.
// Backpressure: wr_rdy_o is a decode of the registered count only; flush drops push and pop.
module alu_skid_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wr_dat_i,
    output logic         wr_rdy_o,
    output logic         rd_vld_o,
    output logic [W-1:0] rd_dat_o
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign wr_rdy_o = (count_q != FULL);
    assign rd_vld_o = (count_q != 2'd0);
    assign do_push  = push_i && wr_rdy_o && !flush_i;
    assign do_pop   = pop_i && rd_vld_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/alu_flag_stage.sv
// Buffers ALU results and commits {Z,V,N} flags as each entry is consumed; 1-cycle latency.
// Backpressure: in_ready = buffer not full (registered count); flush discards entries and pending commits.
module alu_flag_stage
    import alu_flag_stage_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic [3:0]    in_opcode,
    input  logic          in_ovfl,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [2:0]    flags
);

    localparam int EW = DW + $bits(meta_t);

    meta_t         wr_meta;
    meta_t         rd_meta;
    logic [DW-1:0] rd_result;
    logic [EW-1:0] rd_dat;
    logic          pop_hs;
    logic [2:0]    upd_mask;
    logic [2:0]    new_flags;
    logic [2:0]    flags_q, flags_d;

    assign wr_meta = '{opcode: in_opcode, ovfl: in_ovfl};

    alu_skid_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (in_valid),
        .pop_i    (out_ready),
        .flush_i  (flush),
        .wr_dat_i ({wr_meta, in_result}),
        .wr_rdy_o (in_ready),
        .rd_vld_o (out_valid),
        .rd_dat_o (rd_dat)
    );

    assign {rd_meta, rd_result} = rd_dat;
    assign out_result = rd_result;
    assign pop_hs     = out_valid && out_ready;

    always_comb begin
        upd_mask          = flag_mask(rd_meta.opcode);
        new_flags         = 3'b000;
        new_flags[FLAG_Z] = (rd_result == '0);
        new_flags[FLAG_V] = rd_meta.ovfl;
        new_flags[FLAG_N] = rd_result[DW-1];
        flags_d           = flags_q;
        if (pop_hs && !flush) begin
            flags_d = (flags_q & ~upd_mask) | (new_flags & upd_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule
